arrow_lanes: RTL and testbench
==============================

// Module: arrow_lanes
// PURPOSE
//  Parametrised DDR note-lane engine: LANES columns, each holding up to SLOTS rising arrows.
//  Spawns, moves (once per frame), hit-judges against button presses and retires arrows;
//  emits per-lane pixel masks for the VGA colour mux plus hit/miss/drop pulses and a combo count.
//  Sits between the VGA timing generator (sx/sy/frame) and the pixel/score logic.
// PARAMETERS
//  CORDW        10   screen coordinate width
//  LANES        4    number of lanes (lane 0 leftmost)
//  SLOTS        2    concurrent arrows per lane
//  ARROW_SIZE   50   arrow/target box side, pixels (box spans y..y+ARROW_SIZE inclusive)
//  ARROW_GAP    15   horizontal gap between lanes
//  ARROWX_BEGIN 197  left x of lane 0
//  SPAWN_Y      450  y of a newly spawned arrow
//  TARGET_Y     40   y of target box; hit window centre
//  HIT_WIN      12   +/- hit tolerance in pixels; TARGET_Y >= HIT_WIN required
//  ARROW_SPEED  7    pixels moved up per frame
// PORTS
//  clk_i      in   1          pixel clock
//  rst_ni     in   1          asynchronous active-low reset
//  sx_i       in   CORDW      current pixel x
//  sy_i       in   CORDW      current pixel y
//  frame_i    in   1          one-cycle frame-start strobe
//  spawn_i    in   LANES      spawn request per lane (level, sampled each cycle)
//  btn_i      in   LANES      synchronised, debounced buttons (active high)
//  arrow_o    out  LANES      pixel inside any valid arrow of the lane
//  target_o   out  LANES      pixel inside lane's target box
//  hit_o      out  LANES      1-cycle pulse: arrow hit in lane
//  miss_o     out  LANES      1-cycle pulse: arrow left window unhit
//  drop_o     out  LANES      1-cycle pulse: spawn refused, lane full
//  combo_o    out  8          consecutive hits, saturates at 255
// BEHAVIOUR
//  - Bit packing: lane l maps to bit LANES-1-l of every LANES-wide port ({left,up,down,right}).
//  - Reset (async, rst_ni=0): all slots invalid, y=SPAWN_Y, btn history 0, hit/miss/drop 0, combo 0.
//  - Lane x: LX(l)=ARROWX_BEGIN+l*(ARROW_SIZE+ARROW_GAP); all pixel maths in CORDW+1 bits, no wrap.
//  - arrow_o/target_o: combinational from registered slot state and sx_i/sy_i, 0-cycle latency.
//    target box: sx in [LX,LX+SIZE], sy in [TARGET_Y,TARGET_Y+SIZE].
//  - Press = btn_i & ~btn_q (rising edge; btn_q registered every cycle).
//  - Hit: on press in lane l, candidates = valid slots with TARGET_Y-HIT_WIN <= y <= TARGET_Y+HIT_WIN
//    (pre-move y). Lowest-index candidate invalidated; hit_o[l] pulses next cycle.
//    Press with no candidate: no effect, no pulse. Holding a button never re-triggers.
//  - Move: on frame_i, each valid slot not hit this cycle: if y < TARGET_Y-HIT_WIN+ARROW_SPEED,
//    invalidate and pulse miss_o[l] next cycle; else y <= y-ARROW_SPEED. No unsigned underflow.
//  - Hit and miss on same slot same cycle: hit wins, no miss.
//  - Multiple misses in one lane same frame: single miss_o pulse; combo still clears.
//  - Spawn: spawn_i[l]=1 takes lowest slot invalid at start of cycle; y<=SPAWN_Y, valid<=1.
//    Slot freed this cycle is not reusable until next cycle. No free slot: drop_o[l] pulses.
//    Spawned arrow is not moved on a coincident frame_i. Caller holds spawn_i one cycle per note.
//  - combo: any miss in any lane clears to 0 (clear beats increment); else += number of lanes hit
//    this cycle, saturating at 255. Drops do not affect combo.
//  - hit_o/miss_o/drop_o registered: asserted exactly one cycle, one cycle after event.
//  - Lanes fully independent apart from combo_o.
// TESTING
//  1 Reset: rst_ni=0 mid-run -> arrow_o=0, all pulses 0, combo_o=0 immediately (async).
//  2 Spawn lane0, 58 frames -> y 450..44 step 7; press btn lane0 at y=44 -> hit_o=4'b1000
//    next cycle, arrow_o[3] never set again, combo_o=1.
//  3 Spawn lane3, no press -> y reaches 37 (<28+7 false) then 30 (<35) -> next frame slot
//    cleared, miss_o=4'b0001 one cycle, combo_o=0.
//  4 SLOTS=2: three spawn pulses lane1 -> third gives drop_o=4'b0100; after one miss, spawn accepted.
//  5 Same cycle: frame_i + press lane2 with arrow at y=30 -> hit not miss; spawn+frame -> y=450.
//  6 Pixel: arrow lane1 y=100 -> arrow_o[2]=1 at (262,100),(312,150); 0 at (313,100),(262,151).

Source files
------------

// File: rtl/arrow_lanes.sv
// DDR note-lane engine: per-lane arrow slots that spawn, rise once per frame, are judged
// against button presses, and drive pixel masks plus hit/miss/drop pulses and a combo count.
module arrow_lanes #(
    parameter int unsigned CORDW        = 10,
    parameter int unsigned LANES        = 4,
    parameter int unsigned SLOTS        = 2,
    parameter int unsigned ARROW_SIZE   = 50,
    parameter int unsigned ARROW_GAP    = 15,
    parameter int unsigned ARROWX_BEGIN = 197,
    parameter int unsigned SPAWN_Y      = 450,
    parameter int unsigned TARGET_Y     = 40,
    parameter int unsigned HIT_WIN      = 12,
    parameter int unsigned ARROW_SPEED  = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CORDW-1:0] sx_i,
    input  logic [CORDW-1:0] sy_i,
    input  logic             frame_i,
    input  logic [LANES-1:0] spawn_i,
    input  logic [LANES-1:0] btn_i,
    output logic [LANES-1:0] arrow_o,
    output logic [LANES-1:0] target_o,
    output logic [LANES-1:0] hit_o,
    output logic [LANES-1:0] miss_o,
    output logic [LANES-1:0] drop_o,
    output logic [7:0]       combo_o
);

    localparam int unsigned PW = CORDW + 1;
    localparam logic [PW-1:0]    WIN_LO   = PW'(TARGET_Y - HIT_WIN);
    localparam logic [PW-1:0]    WIN_HI   = PW'(TARGET_Y + HIT_WIN);
    localparam logic [PW-1:0]    MISS_LIM = PW'(TARGET_Y - HIT_WIN + ARROW_SPEED);
    localparam logic [PW-1:0]    SPEED_W  = PW'(ARROW_SPEED);
    localparam logic [PW-1:0]    SIZE_W   = PW'(ARROW_SIZE);
    localparam logic [PW-1:0]    TGT_W    = PW'(TARGET_Y);
    localparam logic [CORDW-1:0] SPAWN_YC = CORDW'(SPAWN_Y);

    logic [SLOTS-1:0] valid_q [LANES];
    logic [SLOTS-1:0] valid_d [LANES];
    logic [CORDW-1:0] y_q     [LANES][SLOTS];
    logic [CORDW-1:0] y_d     [LANES][SLOTS];
    logic [LANES-1:0] btn_q;
    logic [LANES-1:0] hit_d, miss_d, drop_d;
    logic [7:0]       combo_d;

    // Slot state, button history and registered event outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < int'(LANES); l++) begin
                valid_q[l] <= '0;
                for (int s = 0; s < int'(SLOTS); s++) y_q[l][s] <= SPAWN_YC;
            end
            btn_q   <= '0;
            hit_o   <= '0;
            miss_o  <= '0;
            drop_o  <= '0;
            combo_o <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            btn_q   <= btn_i;
            hit_o   <= hit_d;
            miss_o  <= miss_d;
            drop_o  <= drop_d;
            combo_o <= combo_d;
        end
    end

    // Per-lane judge, move and spawn; a hit slot is skipped by the move, spawns only use
    // slots that were already free at the start of the cycle
    always_comb begin
        logic           press, hit_done, spawn_done;
        logic [PW-1:0]  yw;
        logic [8:0]     combo_sum;
        int             b;
        valid_d = valid_q;
        y_d     = y_q;
        hit_d   = '0;
        miss_d  = '0;
        drop_d  = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            b          = int'(LANES) - 1 - l;
            press      = btn_i[b] & ~btn_q[b];
            hit_done   = 1'b0;
            spawn_done = 1'b0;
            for (int s = 0; s < int'(SLOTS); s++) begin
                yw = PW'(y_q[l][s]);
                if (press && !hit_done && valid_q[l][s] && yw >= WIN_LO && yw <= WIN_HI) begin
                    valid_d[l][s] = 1'b0;
                    hit_done      = 1'b1;
                    hit_d[b]      = 1'b1;
                end else if (frame_i && valid_q[l][s]) begin
                    if (yw < MISS_LIM) begin
                        valid_d[l][s] = 1'b0;
                        miss_d[b]     = 1'b1;
                    end else begin
                        y_d[l][s] = CORDW'(yw - SPEED_W);
                    end
                end
                if (spawn_i[b] && !spawn_done && !valid_q[l][s]) begin
                    valid_d[l][s] = 1'b1;
                    y_d[l][s]     = SPAWN_YC;
                    spawn_done    = 1'b1;
                end
            end
            if (spawn_i[b] && !spawn_done) drop_d[b] = 1'b1;
        end

        combo_sum = {1'b0, combo_o};
        for (int l = 0; l < int'(LANES); l++) combo_sum = combo_sum + 9'(hit_d[l]);
        if (|miss_d)                combo_d = '0;
        else if (combo_sum > 9'd255) combo_d = 8'd255;
        else                         combo_d = combo_sum[7:0];
    end

    // Pixel masks for the colour mux, straight from registered slot state
    always_comb begin
        logic [PW-1:0] lx, sxw, syw, yw;
        logic          in_x;
        int            b;
        arrow_o  = '0;
        target_o = '0;
        sxw      = PW'(sx_i);
        syw      = PW'(sy_i);
        for (int l = 0; l < int'(LANES); l++) begin
            b    = int'(LANES) - 1 - l;
            lx   = PW'(ARROWX_BEGIN + unsigned'(l) * (ARROW_SIZE + ARROW_GAP));
            in_x = (sxw >= lx) && (sxw <= lx + SIZE_W);
            if (in_x && syw >= TGT_W && syw <= TGT_W + SIZE_W) target_o[b] = 1'b1;
            for (int s = 0; s < int'(SLOTS); s++) begin
                yw = PW'(y_q[l][s]);
                if (valid_q[l][s] && in_x && syw >= yw && syw <= yw + SIZE_W) arrow_o[b] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arrow_lanes.sv
// Randomised scoreboard bench for arrow_lanes: a lane/arrow list model predicts each cycle's
// registered pulses, combo and pixel masks; a monitor pops and compares after every clock edge.
module tb_arrow_lanes;

    localparam int L     = 4;
    localparam int S     = 2;
    localparam int NCYC  = 6000;
    localparam int LX0   = 197;
    localparam int PITCH = 65;
    localparam int SZ    = 50;
    localparam int TY    = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] sx, sy;
    logic       frame;
    logic [3:0] spawn, btn;
    logic [3:0] arrow, target, hit, miss, drop;
    logic [7:0] combo;

    always #5 clk = ~clk;

    arrow_lanes dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .sx_i    (sx),
        .sy_i    (sy),
        .frame_i (frame),
        .spawn_i (spawn),
        .btn_i   (btn),
        .arrow_o (arrow),
        .target_o(target),
        .hit_o   (hit),
        .miss_o  (miss),
        .drop_o  (drop),
        .combo_o (combo)
    );

    typedef struct packed {
        logic [3:0] hit;
        logic [3:0] miss;
        logic [3:0] drop;
        logic [7:0] combo;
        logic [3:0] arrow;
        logic [3:0] target;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;

    // Reference: each lane is a small array of arrows with a live flag and a y position
    bit m_live[L][S];
    int m_y[L][S];
    bit m_btn_prev[L];
    int m_combo;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int l = 0; l < L; l++) begin
            m_btn_prev[l] = 1'b0;
            for (int s = 0; s < S; s++) begin
                m_live[l][s] = 1'b0;
                m_y[l][s]    = 450;
            end
        end
        m_combo = 0;
    endfunction

    function automatic void m_step(input logic [3:0] sp, input logic [3:0] bt, input logic fr,
                                   output logic [3:0] h, output logic [3:0] m, output logic [3:0] d);
        int nh;
        h = '0; m = '0; d = '0; nh = 0;
        for (int l = 0; l < L; l++) begin
            int  bit_i, hs, fs;
            bit  was[S];
            bit  press;
            bit_i = L - 1 - l;
            press = bt[bit_i] && !m_btn_prev[l];
            m_btn_prev[l] = bt[bit_i];
            for (int s = 0; s < S; s++) was[s] = m_live[l][s];
            hs = -1;
            if (press)
                for (int s = 0; s < S; s++)
                    if (hs < 0 && was[s] && m_y[l][s] >= TY - 12 && m_y[l][s] <= TY + 12) hs = s;
            if (hs >= 0) begin
                m_live[l][hs] = 1'b0;
                h[bit_i] = 1'b1;
                nh++;
            end
            if (fr)
                for (int s = 0; s < S; s++)
                    if (was[s] && s != hs) begin
                        if (m_y[l][s] - 7 < TY - 12) begin
                            m_live[l][s] = 1'b0;
                            m[bit_i] = 1'b1;
                        end else m_y[l][s] = m_y[l][s] - 7;
                    end
            if (sp[bit_i]) begin
                fs = -1;
                for (int s = 0; s < S; s++) if (fs < 0 && !was[s]) fs = s;
                if (fs >= 0) begin
                    m_live[l][fs] = 1'b1;
                    m_y[l][fs]    = 450;
                end else d[bit_i] = 1'b1;
            end
        end
        if (m != 0) m_combo = 0;
        else        m_combo = (m_combo + nh > 255) ? 255 : m_combo + nh;
    endfunction

    function automatic logic [7:0] m_pix(input int x, input int y);
        logic [3:0] a, t;
        a = '0; t = '0;
        for (int l = 0; l < L; l++) begin
            int lx;
            lx = LX0 + l * PITCH;
            if (x >= lx && x <= lx + SZ) begin
                if (y >= TY && y <= TY + SZ) t[L-1-l] = 1'b1;
                for (int s = 0; s < S; s++)
                    if (m_live[l][s] && y >= m_y[l][s] && y <= m_y[l][s] + SZ) a[L-1-l] = 1'b1;
            end
        end
        return {a, t};
    endfunction

    // Pick a pixel, often right on or just outside an arrow or target edge
    task automatic pick_pixel(output int x, output int y);
        int l, s, by, offs[5];
        offs = '{-1, 0, 25, SZ, SZ + 1};
        if ($urandom_range(0, 2) == 0) begin
            x = $urandom_range(150, 500);
            y = $urandom_range(0, 510);
        end else begin
            l  = $urandom_range(0, L - 1);
            s  = $urandom_range(0, S - 1);
            by = (m_live[l][s] && $urandom_range(0, 3) != 0) ? m_y[l][s] : TY;
            x  = LX0 + l * PITCH + offs[$urandom_range(0, 4)];
            y  = by + offs[$urandom_range(0, 4)];
        end
    endtask

    task automatic push_cycle(input logic [3:0] sp, input logic [3:0] bt, input logic fr);
        exp_t       e;
        logic [3:0] h, m, d;
        logic [7:0] p;
        int         x, y;
        if (rst_n) m_step(sp, bt, fr, h, m, d);
        else begin h = '0; m = '0; d = '0; end
        pick_pixel(x, y);
        p        = m_pix(x, y);
        spawn    = sp;
        btn      = bt;
        frame    = fr;
        sx       = 10'(x);
        sy       = 10'(y);
        e.hit    = h;
        e.miss   = m;
        e.drop   = d;
        e.combo  = 8'(m_combo);
        e.arrow  = p[7:4];
        e.target = p[3:0];
        q.push_back(e);
        pushed++;
    endtask

    task automatic check_reset_now(input string tag);
        #1;
        check({tag, "_arrow"}, int'(arrow), 0);
        check({tag, "_hit"},   int'(hit),   0);
        check({tag, "_miss"},  int'(miss),  0);
        check({tag, "_drop"},  int'(drop),  0);
        check({tag, "_combo"}, int'(combo), 0);
    endtask

    // Monitor: outputs settle after each rising edge; compare against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                popped++;
                check("hit",    int'(hit),    int'(e.hit));
                check("miss",   int'(miss),   int'(e.miss));
                check("drop",   int'(drop),   int'(e.drop));
                check("combo",  int'(combo),  int'(e.combo));
                check("arrow",  int'(arrow),  int'(e.arrow));
                check("target", int'(target), int'(e.target));
            end
        end
    end

    // Stimulus: random frames, single-cycle spawns and slowly toggling buttons
    initial begin
        logic [3:0] sp, bt;
        logic       fr;
        rst_n = 1'b0;
        sx = '0; sy = '0; frame = 1'b0; spawn = '0; btn = '0;
        bt = '0;
        m_reset();
        @(negedge clk);
        check_reset_now("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (c == NCYC / 2) begin
                rst_n = 1'b0;
                check_reset_now("reset_mid");
                m_reset();
                bt = '0;
                for (int k = 0; k < 2; k++) begin
                    push_cycle('0, '0, 1'b0);
                    @(negedge clk);
                end
                rst_n = 1'b1;
            end
            fr = ($urandom_range(0, 2) == 0);
            sp = '0;
            for (int l = 0; l < L; l++) begin
                if ($urandom_range(0, 79) == 0) sp[l] = 1'b1;
                if ($urandom_range(0, 7) == 0)  bt[l] = ~bt[l];
            end
            push_cycle(sp, bt, fr);
        end
        repeat (3) @(negedge clk);
        check("drain_queue", q.size(), 0);
        check("drain_count", popped, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
